// File: rtl/sr_cmd_debouncer_if.sv
// Button inputs and command/level outputs of the SR front-end debouncer.
// The master side drives the raw buttons; the slave side is the debouncer.
interface sr_cmd_debouncer_if;
    logic set_btn;
    logic clr_btn;
    logic s;
    logic r;
    logic conflict;
    logic set_level;
    logic clr_level;

    modport master (
        output set_btn, clr_btn,
        input  s, r, conflict, set_level, clr_level
    );

    modport slave (
        input  set_btn, clr_btn,
        output s, r, conflict, set_level, clr_level
    );
endinterface

// File: rtl/sr_cmd_debouncer.sv
// Synchronises, debounces and rise-detects the set/clear buttons, then arbitrates
// them into mutually exclusive one-cycle s/r pulses, flagging simultaneous presses.
module sr_cmd_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sr_cmd_debouncer_if.slave    bus
);

    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } level_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 is set, channel 1 is clear.
    logic [1:0] raw;
    logic [1:0] level;
    logic [1:0] rise;

    logic s_q;
    logic r_q;
    logic conflict_q;

    assign raw = {bus.clr_btn, bus.set_btn};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             y1_q;
        logic             y2_q;
        level_e           stable_q;
        logic             stable_dly_q;
        logic [CNT_W-1:0] cnt_q;
        logic             stable_hi;

        assign stable_hi = (stable_q == LVL_HIGH);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                y1_q         <= 1'b0;
                y2_q         <= 1'b0;
                stable_q     <= LVL_LOW;
                stable_dly_q <= 1'b0;
                cnt_q        <= '0;
            end else begin
                y1_q         <= raw[ch];
                y2_q         <= y1_q;
                stable_dly_q <= stable_hi;
                // Any cycle agreeing with the accepted level restarts the count.
                if (y2_q == stable_hi) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    stable_q <= y2_q ? LVL_HIGH : LVL_LOW;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign level[ch] = stable_hi;
        assign rise[ch]  = stable_hi & ~stable_dly_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= rise[0] & ~rise[1];
            r_q        <= rise[1] & ~rise[0];
            conflict_q <= rise[0] & rise[1];
        end
    end

    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.conflict  = conflict_q;
    assign bus.set_level = level[0];
    assign bus.clr_level = level[1];

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer: stimulus queues expected pulses with their
// edge numbers; a negedge monitor pops and compares every pulse the DUT emits.
module tb_sr_cmd_debouncer;

    localparam int KIND_S = 0;
    localparam int KIND_R = 1;
    localparam int KIND_C = 2;

    typedef struct {
        int kind;
        int edge_at;
    } exp_t;

    logic clk;
    logic reset;
    int   edge_n;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    sr_cmd_debouncer_if bus ();

    sr_cmd_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic expect_pulse(input int kind, input int at);
        exp_t e;
        e.kind    = kind;
        e.edge_at = at;
        sb.push_back(e);
    endtask

    task automatic goto(input int tgt);
        while (edge_n < tgt) @(negedge clk);
    endtask

    function automatic int outs();
        return {27'd0, bus.s, bus.r, bus.conflict, bus.set_level, bus.clr_level};
    endfunction

    // Monitor: every emitted pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        int   kind;
        exp_t e;
        n_cmp++;
        if ((bus.s & bus.r) | (bus.conflict & (bus.s | bus.r))) begin
            n_bad++;
            $display("FAIL exclusive: got s=%0b r=%0b conflict=%0b, required at most one high (edge %0d)",
                     bus.s, bus.r, bus.conflict, edge_n);
        end
        if (bus.s | bus.r | bus.conflict) begin
            kind = bus.conflict ? KIND_C : (bus.r ? KIND_R : KIND_S);
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got kind %0d at edge %0d, required no pulse", kind, edge_n);
            end else begin
                e = sb.pop_front();
                if (e.kind != kind || e.edge_at != edge_n) begin
                    n_bad++;
                    $display("FAIL pulse: got kind %0d at edge %0d, required kind %0d at edge %0d",
                             kind, edge_n, e.kind, e.edge_at);
                end
            end
        end
    end

    initial begin
        int e0;
        int e1;
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;

        // 1. Reset: everything low, then reset mid-pulse kills s asynchronously.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outs", outs(), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        bus.set_btn = 1'b1;
        e0 = edge_n + 1;
        expect_pulse(KIND_S, e0 + 6);
        goto(e0 + 6);
        check("s_before_reset", int'(bus.s), 1);
        #1 reset = 1'b0;
        #1 check("s_async_clear", int'(bus.s), 0);
        check("lvl_async_clear", int'(bus.set_level), 0);
        bus.set_btn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_hold_outs", outs(), 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_abort", outs(), 0);

        // 2. Clean set press, held 20 cycles, then released.
        bus.set_btn = 1'b1;
        e0 = edge_n + 1;
        expect_pulse(KIND_S, e0 + 6);
        goto(e0 + 4);
        check("set_level_pre", int'(bus.set_level), 0);
        goto(e0 + 5);
        check("set_level_rise", int'(bus.set_level), 1);
        goto(e0 + 19);
        check("clr_level_quiet", int'(bus.clr_level), 0);
        bus.set_btn = 1'b0;
        e1 = edge_n + 1;
        goto(e1 + 4);
        check("set_level_hold", int'(bus.set_level), 1);
        goto(e1 + 5);
        check("set_level_fall", int'(bus.set_level), 0);
        repeat (4) @(negedge clk);

        // 3. Bounce runs of 1,2,3,1 cycles are rejected; the final settle is accepted.
        bus.set_btn = 1'b1; @(negedge clk);
        bus.set_btn = 1'b0; repeat (2) @(negedge clk);
        bus.set_btn = 1'b1; repeat (3) @(negedge clk);
        bus.set_btn = 1'b0; @(negedge clk);
        check("bounce_level", int'(bus.set_level), 0);
        bus.set_btn = 1'b1;
        e0 = edge_n + 1;
        expect_pulse(KIND_S, e0 + 6);
        goto(e0 + 12);
        check("bounce_settled", int'(bus.set_level), 1);
        bus.set_btn = 1'b0;
        repeat (8) @(negedge clk);

        // 4. Simultaneous press resolves to conflict only.
        bus.set_btn = 1'b1;
        bus.clr_btn = 1'b1;
        e0 = edge_n + 1;
        expect_pulse(KIND_C, e0 + 6);
        goto(e0 + 7);
        check("both_levels", int'({bus.set_level, bus.clr_level}), 3);
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        repeat (8) @(negedge clk);
        check("both_levels_low", int'({bus.set_level, bus.clr_level}), 0);

        // 5. Staggered press: s then r on consecutive cycles.
        bus.set_btn = 1'b1;
        e0 = edge_n + 1;
        expect_pulse(KIND_S, e0 + 6);
        expect_pulse(KIND_R, e0 + 7);
        @(negedge clk);
        bus.clr_btn = 1'b1;
        goto(e0 + 10);
        bus.set_btn = 1'b0;
        bus.clr_btn = 1'b0;
        repeat (8) @(negedge clk);

        // 6. Button held through reset is a fresh press; release and re-press repeats it.
        bus.set_btn = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("held_reset_outs", outs(), 0);
        reset = 1'b1;
        e0 = edge_n + 1;
        expect_pulse(KIND_S, e0 + 6);
        goto(e0 + 10);
        bus.set_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("released_level", int'(bus.set_level), 0);
        bus.set_btn = 1'b1;
        e0 = edge_n + 1;
        expect_pulse(KIND_S, e0 + 6);
        goto(e0 + 10);
        bus.set_btn = 1'b0;
        repeat (8) @(negedge clk);

        check("pending_pulses", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_cmd_debouncer.md
# sr_cmd_debouncer

Front-end stage that sits directly upstream of the SR flip-flop and produces its `s`/`r` inputs. It takes two raw, asynchronous, bouncing push-button inputs (set and clear) and synchronises, debounces and edge-detects each one. It emits clean single-cycle `s` and `r` command pulses that are never asserted together. A simultaneous set/clear press is resolved to "hold" and flagged on a `conflict` pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a level change; legal range is 2 or more.
- `CNT_W`, default 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  in  1  single clock for all state; rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `set_btn`  in  1  raw set button; asynchronous and may bounce.
- `clr_btn`  in  1  raw clear button; asynchronous and may bounce.
- `s`  out  1  one-cycle set command to the SR flip-flop.
- `r`  out  1  one-cycle reset command to the SR flip-flop.
- `conflict`  out  1  one-cycle flag: both presses were accepted on the same edge and dropped.
- `set_level`  out  1  debounced level of `set_btn`.
- `clr_level`  out  1  debounced level of `clr_btn`.

## Operation
- **Synchroniser:** each channel has a 2-flop synchroniser. Raw input → `y1` → `y2`.
- **Debounce FSM, per channel:** state is a `stable` bit plus a counter `cnt`.
  - If `y2 == stable`: `cnt <= 0`.
  - If `y2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `y2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= y2`, `cnt <= 0`.
  - Any single cycle with `y2 == stable` restarts the count. Bounce shorter than `DEBOUNCE_CYCLES` cycles is therefore rejected.
- **Edge detect:** a `stable_d` register holds `stable` delayed by one cycle. `rise = stable & ~stable_d`. Falling edges generate no command.
- **Arbiter (registered outputs):**
  - `s <= set_rise & ~clr_rise`.
  - `r <= clr_rise & ~set_rise`.
  - `conflict <= set_rise & clr_rise`.
- **Invariants:**
  - `s & r` is never 1.
  - `conflict` implies `s == 0` and `r == 0`.
  - A held button produces exactly one pulse. Release followed by a new press is required for another pulse.
- `set_level` and `clr_level` are the per-channel `stable` bits.
- If the set and clear rises are accepted on different edges, both pulses are emitted in order, even one cycle apart.

## Timing
- **Reset values:** all flops clear asynchronously while `reset` = 0. This covers `y1`, `y2`, `stable`, `stable_d`, `cnt`, `s`, `r` and `conflict`. Every output reads 0 during reset.
- **Reset release:** the block resumes on the first rising `clk` after `reset` returns to 1. No synchronous reset term.
- **Press latency:** a raw input sampled high at edge E (and held clean) gives:
  - `y2` = 1 after edge E+1.
  - `stable` = 1 after edge E+DEBOUNCE_CYCLES+1.
  - `s` (or `r`) high for exactly one cycle after edge E+DEBOUNCE_CYCLES+2.
  - With the default of 4, that is 6 edges after first sampling.
- **Release latency:** same path. `set_level` falls after edge E+DEBOUNCE_CYCLES+1 relative to the first low sample. No pulse is generated.
- **Counter boundary:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and does not wrap.
- **Button held through reset:** `stable` restarts at 0. A button still held when `reset` deasserts is accepted as a new press with the normal latency.
- **Reset mid-debounce or mid-pulse:** the operation is aborted immediately. Outputs drop to 0 asynchronously and no pulse is emitted after release unless the input is still high.

## Test plan
Common setup: `DEBOUNCE_CYCLES`=4, clk period 10 ns.

1. **Reset:** hold `reset`=0 for 3 cycles with `set_btn`=`clr_btn`=0 → `s`=`r`=`conflict`=`set_level`=`clr_level`=0 throughout. Assert `reset`=0 mid-cycle while `s`=1 → `s` goes to 0 before the next edge.
2. **Clean set press:** `set_btn` rises just before edge E and is held 20 cycles → `s`=1 for exactly one cycle after edge E+6. `set_level`=1 from edge E+5. `r`=0 and `conflict`=0 throughout.
3. **Bounce rejection:** `set_btn` toggles 1,0,1,0 at cycles of length 1, 2, 3 and 1 (all runs shorter than 4), then settles at 1 → exactly one `s` pulse, 6 edges after the final stable rise. No pulse from the glitches.
4. **Simultaneous press:** `set_btn` and `clr_btn` rise before the same edge and are held → `conflict`=1 for one cycle after E+6. `s`=`r`=0 throughout. Both level outputs reach 1.
5. **Staggered press:** `clr_btn` rises 1 cycle after `set_btn` → `s` pulse after E+6 and `r` pulse after E+7. The two are never high on the same cycle.
6. **Press held through reset:** `set_btn`=1 during reset, then reset released before edge R → `s` pulse after edge R+6, assuming `set_btn` is synchronised from R. Release then re-press after 10 cycles → a second `s` pulse with the same latency.
